// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game blocks: bird FSM state encoding
// and the default playfield height used by the pipe, display and motion logic.
package flappy_pkg;

  localparam int ROWS_DEFAULT = 16;
  localparam int RISE_CNT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FALL = 2'd1,
    ST_RISE = 2'd2,
    ST_DEAD = 2'd3
  } bird_state_e;

endpackage

// File: rtl/tick_gen.sv
// Motion-step divider: counts 0..TICK_DIV-1 while run is high and emits a
// one-cycle tick on the terminal count; held at zero whenever run is low.
module tick_gen #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic tick
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [CNT_W-1:0] r_cnt;

  // NOTE: sequential state is always written with non-blocking assignments so
  // every flop samples pre-edge values regardless of block evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (!run || r_cnt == CNT_LAST) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_ONE;
    end
  end

  assign tick = run && (r_cnt == CNT_LAST);

endmodule

// File: rtl/bird_motion.sv
// Bird vertical-motion controller: gravity steps down on each tick, flaps buy
// RISE_STEPS upward steps, collisions or hitting the floor end the game.
module bird_motion
  import flappy_pkg::*;
#(
  parameter int ROWS       = ROWS_DEFAULT,
  parameter int TICK_DIV   = 12_500_000,
  parameter int RISE_STEPS = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic                    flap,
  input  logic                    hit,
  output logic [$clog2(ROWS)-1:0] bird_row,
  output logic                    alive,
  output logic                    dead
);

  localparam int ROW_W = $clog2(ROWS);
  localparam logic [ROW_W-1:0]      ROW_MID   = ROW_W'(ROWS / 2);
  localparam logic [ROW_W-1:0]      ROW_MAX   = ROW_W'(ROWS - 1);
  localparam logic [ROW_W-1:0]      ROW_ONE   = ROW_W'(1);
  localparam logic [RISE_CNT_W-1:0] RISE_LOAD = RISE_CNT_W'(RISE_STEPS);
  localparam logic [RISE_CNT_W-1:0] RISE_ONE  = RISE_CNT_W'(1);

  bird_state_e            r_state;
  logic [ROW_W-1:0]       r_row;
  logic [RISE_CNT_W-1:0]  r_rise_cnt;

  logic                   w_run;
  logic                   w_tick;
  logic [ROW_W-1:0]       w_row_up;

  assign w_run    = (r_state == ST_FALL) || (r_state == ST_RISE);
  // The ceiling is a clamp, not a hazard: rising at row 0 stays at row 0.
  assign w_row_up = (r_row == '0) ? r_row : r_row - ROW_ONE;

  tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .reset (reset),
    .run   (w_run),
    .tick  (w_tick)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= ST_IDLE;
      r_row      <= ROW_MID;
      r_rise_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) r_state <= ST_FALL;
        end

        ST_FALL, ST_RISE: begin
          if (hit) begin
            r_state <= ST_DEAD;
          end else if (flap) begin
            // A flap landing on a tick reloads the count and spends one step at once.
            if (w_tick) begin
              r_row      <= w_row_up;
              r_rise_cnt <= RISE_LOAD - RISE_ONE;
              r_state    <= (RISE_LOAD == RISE_ONE) ? ST_FALL : ST_RISE;
            end else begin
              r_rise_cnt <= RISE_LOAD;
              r_state    <= ST_RISE;
            end
          end else if (w_tick) begin
            if (r_state == ST_FALL) begin
              if (r_row == ROW_MAX) r_state <= ST_DEAD;
              else                  r_row   <= r_row + ROW_ONE;
            end else begin
              r_row      <= w_row_up;
              r_rise_cnt <= r_rise_cnt - RISE_ONE;
              if (r_rise_cnt == RISE_ONE) r_state <= ST_FALL;
            end
          end
        end

        ST_DEAD: begin
          if (start) begin
            r_state    <= ST_IDLE;
            r_row      <= ROW_MID;
            r_rise_cnt <= '0;
          end
        end

        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bird_row = r_row;
  assign alive    = w_run;
  assign dead     = (r_state == ST_DEAD);

endmodule

// File: tb/tb_bird_motion.sv
// Self-checking bench for bird_motion: directed game scenarios plus a random
// run compared against a behavioural model of the game rules.
module tb_bird_motion;

  localparam int ROWS       = 16;
  localparam int TICK_DIV   = 4;
  localparam int RISE_STEPS = 2;

  logic       clk = 1'b0;
  logic       reset;
  logic       start;
  logic       flap;
  logic       hit;
  logic [3:0] bird_row;
  logic       alive;
  logic       dead;

  int n_checks = 0;
  int n_fail   = 0;

  // Behavioural model of the game rules.
  bit m_playing;
  bit m_dead;
  int m_row;
  int m_rise_left;
  int m_elapsed;

  bird_motion #(
    .ROWS       (ROWS),
    .TICK_DIV   (TICK_DIV),
    .RISE_STEPS (RISE_STEPS)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .flap     (flap),
    .hit      (hit),
    .bird_row (bird_row),
    .alive    (alive),
    .dead     (dead)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_playing   = 1'b0;
    m_dead      = 1'b0;
    m_row       = ROWS / 2;
    m_rise_left = 0;
    m_elapsed   = 0;
  endtask

  task automatic model_edge(input bit s, input bit f, input bit h);
    bit step_now;
    if (m_dead) begin
      if (s) begin
        m_dead      = 1'b0;
        m_row       = ROWS / 2;
        m_rise_left = 0;
      end
    end else if (!m_playing) begin
      if (s) begin
        m_playing = 1'b1;
        m_elapsed = 0;
      end
    end else begin
      m_elapsed = m_elapsed + 1;
      step_now  = (m_elapsed % TICK_DIV) == 0;
      if (h) begin
        m_playing = 1'b0;
        m_dead    = 1'b1;
      end else begin
        if (f) m_rise_left = RISE_STEPS;
        if (step_now) begin
          if (m_rise_left > 0) begin
            m_row       = (m_row > 0) ? m_row - 1 : 0;
            m_rise_left = m_rise_left - 1;
          end else if (m_row == ROWS - 1) begin
            m_playing = 1'b0;
            m_dead    = 1'b1;
          end else begin
            m_row = m_row + 1;
          end
        end
      end
    end
  endtask

  // One clock: present inputs, take the edge, sample 1 ns later.
  task automatic step(input bit s, input bit f, input bit h);
    start = s;
    flap  = f;
    hit   = h;
    @(posedge clk);
    model_edge(s, f, h);
    #1;
    start = 1'b0;
    flap  = 1'b0;
    hit   = 1'b0;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Called just after an edge sample point, so the pulse never spans an edge.
  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    #2;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    start = 1'b0;
    flap  = 1'b0;
    hit   = 1'b0;
    model_reset();
    #13;
    n_checks++;
    if (bird_row !== 4'd8 || alive !== 1'b0 || dead !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_values: row=%0d alive=%b dead=%b, required row=8 alive=0 dead=0",
               bird_row, alive, dead);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b1);
    steps(6);
    n_checks++;
    if (bird_row !== 4'd8 || alive !== 1'b0 || dead !== 1'b0) begin
      n_fail++;
      $display("FAIL idle_ignores_inputs: row=%0d alive=%b dead=%b, required row=8 alive=0 dead=0",
               bird_row, alive, dead);
    end
  endtask

  task automatic test_fall_to_floor();
    int exp_row;
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bird_row !== 4'd8 || alive !== 1'b1 || dead !== 1'b0) begin
      n_fail++;
      $display("FAIL fall_start: row=%0d alive=%b dead=%b, required row=8 alive=1 dead=0",
               bird_row, alive, dead);
    end
    steps(3);
    n_checks++;
    if (bird_row !== 4'd8) begin
      n_fail++;
      $display("FAIL fall_no_early_tick: row=%0d, required 8", bird_row);
    end
    step(1'b0, 1'b0, 1'b0);
    for (int k = 1; k <= 7; k++) begin
      if (k > 1) steps(TICK_DIV);
      exp_row = 8 + k;
      n_checks++;
      if (bird_row !== 4'(exp_row)) begin
        n_fail++;
        $display("FAIL fall_row_%0d: row=%0d, required %0d", k, bird_row, exp_row);
      end
    end
    steps(TICK_DIV);
    n_checks++;
    if (bird_row !== 4'd15 || alive !== 1'b0 || dead !== 1'b1) begin
      n_fail++;
      $display("FAIL floor_death: row=%0d alive=%b dead=%b, required row=15 alive=0 dead=1",
               bird_row, alive, dead);
    end
    step(1'b0, 1'b1, 1'b1);
    steps(5);
    n_checks++;
    if (bird_row !== 4'd15 || dead !== 1'b1) begin
      n_fail++;
      $display("FAIL dead_holds: row=%0d dead=%b, required row=15 dead=1", bird_row, dead);
    end
  endtask

  task automatic test_flap_early();
    int exp_rows [4] = '{7, 6, 7, 8};
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0);
    steps(2);
    for (int k = 0; k < 4; k++) begin
      if (k > 0) steps(TICK_DIV);
      n_checks++;
      if (bird_row !== 4'(exp_rows[k]) || alive !== 1'b1) begin
        n_fail++;
        $display("FAIL flap_early_%0d: row=%0d alive=%b, required row=%0d alive=1",
                 k, bird_row, alive, exp_rows[k]);
      end
    end
  endtask

  task automatic test_flap_on_tick();
    int exp_rows [3] = '{7, 6, 7};
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    steps(3);
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      if (k > 0) steps(TICK_DIV);
      n_checks++;
      if (bird_row !== 4'(exp_rows[k])) begin
        n_fail++;
        $display("FAIL flap_on_tick_%0d: row=%0d, required %0d", k, bird_row, exp_rows[k]);
      end
    end
  endtask

  task automatic test_ceiling();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 48; i++) step(1'b0, 1'b1, 1'b0);
    n_checks++;
    if (bird_row !== 4'd0 || dead !== 1'b0 || alive !== 1'b1) begin
      n_fail++;
      $display("FAIL ceiling_clamp: row=%0d alive=%b dead=%b, required row=0 alive=1 dead=0",
               bird_row, alive, dead);
    end
  endtask

  task automatic test_hit_with_flap();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    steps(2 * TICK_DIV);
    n_checks++;
    if (bird_row !== 4'd10) begin
      n_fail++;
      $display("FAIL hit_setup_row: row=%0d, required 10", bird_row);
    end
    step(1'b0, 1'b1, 1'b1);
    n_checks++;
    if (bird_row !== 4'd10 || dead !== 1'b1 || alive !== 1'b0) begin
      n_fail++;
      $display("FAIL hit_death: row=%0d alive=%b dead=%b, required row=10 alive=0 dead=1",
               bird_row, alive, dead);
    end
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (bird_row !== 4'd8 || dead !== 1'b0 || alive !== 1'b0) begin
      n_fail++;
      $display("FAIL dead_to_idle: row=%0d alive=%b dead=%b, required row=8 alive=0 dead=0",
               bird_row, alive, dead);
    end
  endtask

  task automatic test_async_reset_mid_rise();
    do_reset();
    step(1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    n_checks++;
    if (alive !== 1'b1 || dead !== 1'b0 || bird_row !== 4'd8) begin
      n_fail++;
      $display("FAIL start_ignored_in_fall: row=%0d alive=%b dead=%b, required row=8 alive=1 dead=0",
               bird_row, alive, dead);
    end
    step(1'b0, 1'b1, 1'b0);
    steps(2);
    n_checks++;
    if (bird_row !== 4'd7 || alive !== 1'b1) begin
      n_fail++;
      $display("FAIL rise_before_reset: row=%0d alive=%b, required row=7 alive=1", bird_row, alive);
    end
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    #1;
    n_checks++;
    if (bird_row !== 4'd8 || alive !== 1'b0 || dead !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: row=%0d alive=%b dead=%b, required row=8 alive=0 dead=0",
               bird_row, alive, dead);
    end
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    step(1'b0, 1'b1, 1'b0);
    steps(2 * TICK_DIV);
    n_checks++;
    if (bird_row !== 4'd8 || alive !== 1'b0 || dead !== 1'b0) begin
      n_fail++;
      $display("FAIL needs_start_after_reset: row=%0d alive=%b dead=%b, required row=8 alive=0 dead=0",
               bird_row, alive, dead);
    end
  endtask

  task automatic test_random_play();
    bit s, f, h;
    int bad = 0;
    do_reset();
    for (int i = 0; i < 4000; i++) begin
      s = ($urandom % 30) == 0;
      f = ($urandom % 7) == 0;
      h = ($urandom % 80) == 0;
      step(s, f, h);
      n_checks++;
      if (bird_row !== 4'(m_row) || alive !== m_playing || dead !== m_dead) begin
        n_fail++;
        bad++;
        if (bad <= 10)
          $display("FAIL random_cycle_%0d: row=%0d alive=%b dead=%b, required row=%0d alive=%b dead=%b",
                   i, bird_row, alive, dead, m_row, m_playing, m_dead);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fall_to_floor();
    test_flap_early();
    test_flap_on_tick();
    test_ceiling();
    test_hit_with_flap();
    test_async_reset_mid_rise();
    test_random_play();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bird_motion.md
BIRD_MOTION -- requirements
Module: bird_motion

Interface
REQ-001 SHALL have parameter ROWS, default 16, number of display rows; row 0 is top, row ROWS-1 is bottom.
REQ-002 SHALL have parameter TICK_DIV, default 12_500_000, clk cycles per motion step (>=2).
REQ-003 SHALL have parameter RISE_STEPS, default 2, upward steps per flap (1..7).
REQ-004 clk  input  1  single system clock, all state on posedge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 start  input  1  one-cycle pulse: begin game from IDLE, or return to IDLE from DEAD.
REQ-007 flap  input  1  one-cycle pulse from the key edge detector; requests upward motion.
REQ-008 hit  input  1  level from pipe/collision logic; bird overlaps a pipe.
REQ-009 bird_row  output  $clog2(ROWS)  current bird row.
REQ-010 alive  output  1  high in FALL or RISE.
REQ-011 dead  output  1  high in DEAD.

Function
REQ-012 SHALL implement states IDLE, FALL, RISE and DEAD.
REQ-013 IDLE: bird_row = ROWS/2; flap and hit ignored; start -> FALL.
REQ-014 SHALL contain a tick divider counting 0..TICK_DIV-1 only in FALL/RISE; tick is high for exactly one cycle when count = TICK_DIV-1, after which the count wraps to 0.
REQ-015 Divider SHALL be held at 0 in IDLE and DEAD and cleared in the start cycle, so the first tick comes TICK_DIV cycles after start.
REQ-016 FALL, on tick: if bird_row = ROWS-1 -> DEAD (row held); else bird_row+1.
REQ-017 flap in FALL or RISE SHALL load rise_cnt = RISE_STEPS and enter/stay in RISE; a flap during RISE restarts the count.
REQ-018 RISE, on tick: bird_row-1, saturating at 0 (ceiling clamp, no death); rise_cnt-1; when rise_cnt reaches 0 -> FALL.
REQ-019 flap and tick in the same cycle: flap wins; rise_cnt loads RISE_STEPS, the tick moves up one row and rise_cnt ends at RISE_STEPS-1.
REQ-020 hit high in FALL or RISE -> DEAD on the next edge, with priority over flap and tick; bird_row frozen at its current value.
REQ-021 DEAD: bird_row held, flap/hit ignored; start -> IDLE (bird_row = ROWS/2 on entry).
REQ-022 start in FALL or RISE SHALL be ignored.
REQ-023 All outputs SHALL be registered or decoded from registered state only; no combinational path from inputs to outputs.

Reset
REQ-024 reset low SHALL immediately force IDLE, bird_row = ROWS/2, rise_cnt = 0, divider = 0, alive = 0, dead = 0, regardless of clk.
REQ-025 Reset asserted mid-game (any state) SHALL abandon the game; after release, start is required to play.

Structure
REQ-026 State enum and ROWS default SHALL live in shared package flappy_pkg for use by the pipe and display blocks.
REQ-027 Divider SHALL be sub-module tick_gen (ports clk, reset, run, tick; parameter TICK_DIV).
REQ-028 flap SHALL be consumed as-is; the block SHALL NOT re-edge-detect it.

Verification (TICK_DIV=4, ROWS=16, RISE_STEPS=2)
REQ-029 reset low, then start pulse, no flap -> row 8, then 9,10..15 at 4-cycle spacing; tick at row 15 -> dead=1, row 15, alive=0.
REQ-030 After start, flap at cycle 2 -> next two ticks give rows 7,6, then falling resumes 7,8,...
REQ-031 flap coincident with tick at row 8 -> row 7 that edge; next tick row 6; then FALL.
REQ-032 Repeated flaps up to row 0 -> bird_row stays 0, dead stays 0.
REQ-033 hit asserted at row 10 with simultaneous flap -> dead=1 next edge, row 10; start -> IDLE, row 8.
REQ-034 reset pulsed low mid-RISE between clk edges -> outputs at reset values immediately; start ignored in FALL, verified before reset.
